fixed_div_seq: RTL and testbench

- Multi-cycle signed fixed-point divider: computes a/b on the team's `fixed` format (WIDTH bits, BF fractional bits, two's complement).
- It is the inverse operation of the combinational fixed multiplier. It replaces the single-cycle combinational divide in timing-critical raytracer stages (ray/plane t computation, normalisation).
- Uses a restoring shift-subtract datapath, one quotient bit per cycle, with valid/ready handshakes on input and output.

---
 rtl/fixed_div_seq_pkg.sv | 25 ++
 rtl/fixed_div_core.sv | 66 ++++++
 rtl/fixed_div_seq.sv | 134 +++++++++++++
 tb/tb_fixed_div_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_div_seq_pkg.sv
// Shared definitions for the sequential fixed-point divider.
// Provides the `fixed` format, saturation constants, the divider FSM state
// type and the two's-complement helpers used for magnitude and negation.
package fixed_div_seq_pkg;

  localparam int unsigned _WIDTH = 32;
  localparam int unsigned BF     = 16;

  typedef logic signed [_WIDTH-1:0] fixed;

  localparam fixed FIXED_MAX = {1'b0, {(_WIDTH-1){1'b1}}};
  localparam fixed FIXED_MIN = {1'b1, {(_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIVIDE, FINISH, DONE} div_state_t;

  function automatic logic [_WIDTH-1:0] twos_neg(input logic [_WIDTH-1:0] x);
    return ~x + _WIDTH'(1);
  endfunction

  // Unsigned magnitude; the most negative value maps to 2^(_WIDTH-1).
  function automatic logic [_WIDTH-1:0] twos_abs(input logic [_WIDTH-1:0] x);
    return x[_WIDTH-1] ? twos_neg(x) : x;
  endfunction

endpackage

// File: rtl/fixed_div_core.sv
// Restoring shift-subtract datapath, one quotient bit per step.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   load       : capture magnitudes, clear remainder and iteration count
//   step       : perform one shift/trial-subtract iteration
//   a_mag      : dividend magnitude (shifted left by BF on load)
//   b_mag      : divisor magnitude
//   last       : high during the step that produces the final quotient bit
//   quot       : unsigned quotient, valid after WIDTH+BF steps
module fixed_div_core
  import fixed_div_seq_pkg::*;
#(
  parameter int unsigned WIDTH = fixed_div_seq_pkg::_WIDTH,
  parameter int unsigned BF    = fixed_div_seq_pkg::BF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                step,
  input  logic [WIDTH-1:0]    a_mag,
  input  logic [WIDTH-1:0]    b_mag,
  output logic                last,
  output logic [WIDTH+BF-1:0] quot
);

  localparam int unsigned DW = WIDTH + BF;
  localparam int unsigned CW = $clog2(DW + 1);

  // Remainder always stays below the divisor, so WIDTH bits suffice.
  logic [WIDTH-1:0] rem_q;
  logic [DW-1:0]    dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             fits;

  always_comb begin
    shifted = {rem_q, dvd_q[DW-1]};
    diff    = shifted - {1'b0, dsr_q};
    fits    = shifted >= {1'b0, dsr_q};
  end

  assign last = step && (cnt_q == CW'(DW - 1));
  assign quot = dvd_q;

  // Quotient bits shift into dvd_q as the dividend bits shift out.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      dvd_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      dvd_q <= {a_mag, {BF{1'b0}}};
      dsr_q <= b_mag;
      cnt_q <= '0;
    end else if (step) begin
      rem_q <= fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      dvd_q <= {dvd_q[DW-2:0], fits};
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/fixed_div_seq.sv
// Multi-cycle signed fixed-point divider q = a / b with valid/ready handshakes.
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   in_valid / in_ready   : operand handshake (accepted only in IDLE)
//   a, b                  : dividend and divisor, signed fixed
//   out_valid / out_ready : result handshake, result held until accepted
//   q                     : quotient, truncated toward zero, saturated on error
//   div_by_zero           : b was zero
//   overflow              : quotient magnitude not representable
module fixed_div_seq
  import fixed_div_seq_pkg::*;
#(
  parameter int unsigned WIDTH = fixed_div_seq_pkg::_WIDTH,
  parameter int unsigned BF    = fixed_div_seq_pkg::BF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned DW = WIDTH + BF;

  localparam logic [WIDTH-1:0] QMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] QMIN = {1'b1, {(WIDTH-1){1'b0}}};
  // Largest representable quotient magnitudes for each result sign.
  localparam logic [DW-1:0] POS_LIM = {{(BF+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [DW-1:0] NEG_LIM = {{BF{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state_q;
  logic             sign_q;
  logic             aneg_q;
  logic             bz_q;
  logic             accept;
  logic             core_step;
  logic             core_last;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [DW-1:0]    qu;
  logic [WIDTH-1:0] qlow;
  logic [WIDTH-1:0] qneg;
  logic             ovf;
  logic [WIDTH-1:0] res;

  assign accept    = in_valid && (state_q == IDLE);
  assign core_step = (state_q == DIVIDE);

  always_comb begin
    a_mag = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    b_mag = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
  end

  fixed_div_core #(
    .WIDTH (WIDTH),
    .BF    (BF)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .step  (core_step),
    .a_mag (a_mag),
    .b_mag (b_mag),
    .last  (core_last),
    .quot  (qu)
  );

  always_comb begin
    qlow = qu[WIDTH-1:0];
    qneg = ~qlow + WIDTH'(1);
    ovf  = sign_q ? (qu > NEG_LIM) : (qu > POS_LIM);
    if (bz_q) begin
      res = aneg_q ? QMIN : QMAX;
    end else if (ovf) begin
      res = sign_q ? QMIN : QMAX;
    end else begin
      // Negating zero yields zero, so no -0 special case is needed.
      res = sign_q ? qneg : qlow;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      q           <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      sign_q      <= 1'b0;
      aneg_q      <= 1'b0;
      bz_q        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            in_ready    <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            sign_q      <= a[WIDTH-1] ^ b[WIDTH-1];
            aneg_q      <= a[WIDTH-1];
            bz_q        <= (b == '0);
            state_q     <= (b == '0) ? FINISH : DIVIDE;
          end
        end
        DIVIDE: begin
          if (core_last) state_q <= FINISH;
        end
        FINISH: begin
          q           <= res;
          div_by_zero <= bz_q;
          overflow    <= !bz_q && ovf;
          out_valid   <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_div_seq.sv
module tb_fixed_div_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] q;
  logic        div_by_zero;
  logic        overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  fixed_div_seq dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .q           (q),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        dz;
    logic        ov;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: plain integer division of the magnitudes, then the saturation rules.
  function automatic void model(input logic [31:0] av, input logic [31:0] bv,
                                output logic [31:0] qv, output logic dzv, output logic ovv);
    longint sa, sb, ma, mb, qu;
    bit neg;
    sa  = longint'($signed(av));
    sb  = longint'($signed(bv));
    ma  = (sa < 0) ? -sa : sa;
    mb  = (sb < 0) ? -sb : sb;
    neg = (sa < 0) != (sb < 0);
    dzv = 1'b0;
    ovv = 1'b0;
    if (sb == 0) begin
      dzv = 1'b1;
      qv  = (sa < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      qu = (ma * 65536) / mb;
      if (!neg && qu > 64'sd2147483647) ovv = 1'b1;
      if (neg && qu > 64'sd2147483648) ovv = 1'b1;
      if (ovv) qv = neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
      else qv = neg ? 32'(-qu) : 32'(qu);
    end
  endfunction

  // Drive operands, return at the negedge where out_valid is first seen.
  // lat counts the accepting edge as clock 1.
  task automatic start_op(input logic [31:0] av, input logic [31:0] bv, output int lat);
    @(negedge clk);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, output logic [31:0] qv,
                        output logic dzv, output logic ovv, output int lat);
    start_op(av, bv, lat);
    qv  = q;
    dzv = div_by_zero;
    ovv = overflow;
    handshake();
  endtask

  initial begin
    logic [31:0] rq, eq, ra, rb, qh;
    logic        rdz, rov, edz, eov, ok;
    int          lat, bad;

    vecs[0]  = '{32'h0006_0000, 32'h0002_0000, 32'h0003_0000, 1'b0, 1'b0, 50};
    vecs[1]  = '{32'hFFF8_8000, 32'h0002_8000, 32'hFFFD_0000, 1'b0, 1'b0, 50};
    vecs[2]  = '{32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 1'b0, 1'b0, 50};
    vecs[3]  = '{32'h0001_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2};
    vecs[4]  = '{32'hFFFF_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0, 2};
    vecs[5]  = '{32'h7FFF_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 50};
    vecs[6]  = '{32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 1'b0, 50};
    vecs[7]  = '{32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 1'b0, 1'b0, 50};
    vecs[8]  = '{32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 50};
    vecs[9]  = '{32'h0000_0000, 32'h0005_0000, 32'h0000_0000, 1'b0, 1'b0, 50};
    vecs[10] = '{32'h0000_0001, 32'h0002_0000, 32'h0000_0000, 1'b0, 1'b0, 50};
    vecs[11] = '{32'hFFFF_FFFF, 32'h0002_0000, 32'h0000_0000, 1'b0, 1'b0, 50};
    vecs[12] = '{32'h4000_0000, 32'h0000_8000, 32'h7FFF_FFFF, 1'b0, 1'b1, 50};
    vecs[13] = '{32'hC000_0000, 32'h0000_8000, 32'h8000_0000, 1'b0, 1'b0, 50};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_q", q, 0);
    check("rst_dz", div_by_zero, 0);
    check("rst_ov", overflow, 0);

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].a, vecs[i].b, rq, rdz, rov, lat);
      check($sformatf("vec%0d_q", i), rq, vecs[i].q);
      check($sformatf("vec%0d_dz", i), rdz, vecs[i].dz);
      check($sformatf("vec%0d_ov", i), rov, vecs[i].ov);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
    end

    for (int i = 0; i < 40; i++) begin
      ra = $urandom >> $urandom_range(0, 24);
      rb = $urandom >> $urandom_range(0, 28);
      if ($urandom_range(0, 1) == 1) ra = -ra;
      if ($urandom_range(0, 1) == 1) rb = -rb;
      if ($urandom_range(0, 15) == 0) rb = '0;
      model(ra, rb, eq, edz, eov);
      run_op(ra, rb, rq, rdz, rov, lat);
      check($sformatf("rnd%0d_q a=%h b=%h", i, ra, rb), rq, eq);
      check($sformatf("rnd%0d_flags", i), {rdz, rov}, {edz, eov});
      check($sformatf("rnd%0d_lat", i), lat, (rb == 0) ? 2 : 50);
    end

    // Backpressure: result held, in_ready low, second request ignored.
    start_op(32'h0006_0000, 32'h0002_0000, lat);
    check("bp_lat", lat, 50);
    qh = q;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_valid = 1'b1;
        a        = 32'h0001_0000;
        b        = 32'h0000_0000;
      end
      if (i == 4) in_valid = 1'b0;
      @(negedge clk);
      if (q !== qh || !out_valid || in_ready || div_by_zero || overflow) ok = 1'b0;
    end
    check("bp_stable", ok, 1);
    check("bp_q", q, 32'h0003_0000);
    handshake();
    check("bp_in_ready", in_ready, 1);
    check("bp_out_valid", out_valid, 0);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    check("bp_ignored", bad, 0);

    // Reset partway through the iterations aborts the operation.
    @(negedge clk);
    a        = 32'h0006_0000;
    b        = 32'h0002_0000;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_q", q, 0);
    check("abort_flags", {div_by_zero, overflow}, 2'b00);
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    check("abort_no_result", bad, 0);
    run_op(32'h0006_0000, 32'h0002_0000, rq, rdz, rov, lat);
    check("abort_after_q", rq, 32'h0003_0000);
    check("abort_after_lat", lat, 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
